// File: rtl/spi_frame_tx_pkg.sv
// Shared types and constants for the SPI frame transmitter.
package spi_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAL    = 3'd1,
    SELECT = 3'd2,
    SHIFT  = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } tx_state_t;

  localparam logic SPI_CLK_IDLE = 1'b0;
  localparam logic SPI_CS_IDLE  = 1'b1;

  localparam int unsigned ENTRY_W = 9;

  // One FIFO entry: frame-end flag plus payload byte.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spi_frame_tx_fifo.sv
// Single-clock byte FIFO with a first-word-fall-through head and synchronous flush.
module tx_byte_fifo
  import spi_frame_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        CLK_40,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t rd_entry,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  fifo_entry_t   mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge CLK_40) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI transmitter: FIFO-buffered bytes shifted MSB-first, plus a chip-select-high calibration burst.
module spi_frame_tx
  import spi_frame_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 20,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CAL_CYCLES = 64
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       cal_start,
  output logic       SPI_clk,
  output logic       SPI_mosi,
  output logic       SPI_cs_n,
  output logic       busy,
  output logic       cal_done
);

  localparam int unsigned PH_W  = $clog2(CLK_DIV);
  localparam int unsigned CAL_W = $clog2(2 * CAL_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_PRE   = PH_W'(CLK_DIV - 2);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(2 * CAL_CYCLES - 1);

  tx_state_t        state;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_nxt;
  logic             wrap;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             cur_last;
  logic [CAL_W-1:0] cal_cnt;

  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;

  assign wr_entry   = '{last: byte_last, data: byte_in};
  assign fifo_push  = byte_valid && !fifo_full;
  assign byte_ready = !fifo_full;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK_40   (CLK_40),
    .reset    (reset),
    .push     (fifo_push),
    .wr_entry (wr_entry),
    .pop      (fifo_pop),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wrap      = (phase == PH_LAST);
  assign phase_nxt = wrap ? '0 : phase + PH_W'(1);

  // Pop decision shared with the FSM so the head is consumed exactly when loaded.
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      IDLE:    fifo_pop = !cal_start && !fifo_empty;
      SHIFT:   fifo_pop = wrap && SPI_clk && (bit_idx == 3'd0) && !cur_last && !fifo_empty;
      HOLD:    fifo_pop = !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      cur_last <= 1'b0;
      cal_cnt  <= '0;
      SPI_clk  <= SPI_CLK_IDLE;
      SPI_mosi <= 1'b0;
      SPI_cs_n <= SPI_CS_IDLE;
      busy     <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      cal_done <= 1'b0;
      phase    <= phase_nxt;
      case (state)
        IDLE: begin
          phase <= '0;
          if (cal_start) begin
            state   <= CAL;
            busy    <= 1'b1;
            cal_cnt <= '0;
          end else if (fifo_pop) begin
            state    <= SELECT;
            busy     <= 1'b1;
            SPI_cs_n <= 1'b0;
            shreg    <= head.data;
            SPI_mosi <= head.data[7];
            cur_last <= head.last;
            bit_idx  <= 3'd7;
          end
        end
        CAL: begin
          if ((cal_cnt == CAL_LAST) && (phase == PH_PRE)) cal_done <= 1'b1;
          if (wrap) begin
            SPI_clk <= ~SPI_clk;
            cal_cnt <= cal_cnt + CAL_W'(1);
            if (cal_cnt == CAL_LAST) begin
              SPI_clk <= SPI_CLK_IDLE;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        SELECT: begin
          if (wrap) begin
            SPI_clk <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (wrap) begin
            if (!SPI_clk) begin
              SPI_clk <= 1'b1;
            end else begin
              SPI_clk <= 1'b0;
              if (bit_idx != 3'd0) begin
                SPI_mosi <= shreg[6];
                shreg    <= {shreg[6:0], 1'b0};
                bit_idx  <= bit_idx - 3'd1;
              end else if (cur_last) begin
                state <= GAP;
              end else if (fifo_pop) begin
                shreg    <= head.data;
                SPI_mosi <= head.data[7];
                cur_last <= head.last;
                bit_idx  <= 3'd7;
              end else begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          // Clock parked low; the next rising edge comes CLK_DIV cycles after the reload.
          phase <= '0;
          if (fifo_pop) begin
            shreg    <= head.data;
            SPI_mosi <= head.data[7];
            cur_last <= head.last;
            bit_idx  <= 3'd7;
            state    <= SHIFT;
          end
        end
        GAP: begin
          if (wrap) begin
            SPI_cs_n <= SPI_CS_IDLE;
            SPI_mosi <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: single frames from a vector table plus multi-cycle corner sequences.
module tb_spi_frame_tx;

  localparam int CD = 20;

  logic       CLK_40 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_last = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       cal_start = 1'b0;
  logic       SPI_clk;
  logic       SPI_mosi;
  logic       SPI_cs_n;
  logic       busy;
  logic       cal_done;

  spi_frame_tx #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (16),
    .CAL_CYCLES (4)
  ) dut (
    .CLK_40     (CLK_40),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_last  (byte_last),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cal_start  (cal_start),
    .SPI_clk    (SPI_clk),
    .SPI_mosi   (SPI_mosi),
    .SPI_cs_n   (SPI_cs_n),
    .busy       (busy),
    .cal_done   (cal_done)
  );

  always #5 CLK_40 = ~CLK_40;

  int cyc = 0;
  always @(posedge CLK_40) cyc <= cyc + 1;

  // Line monitor, sampled mid-cycle.
  int rise_cyc[$];
  bit rise_bit[$];
  int cal_rise_cyc[$];
  int cs_fall_cyc[$];
  int cs_rise_cyc[$];
  int cal_done_cyc[$];
  bit mosi_hist[int];
  bit prev_clk = 1'b0;
  bit prev_cs = 1'b1;

  always @(negedge CLK_40) begin
    mosi_hist[cyc] = SPI_mosi;
    if (SPI_clk && !prev_clk) begin
      if (!SPI_cs_n) begin
        rise_cyc.push_back(cyc);
        rise_bit.push_back(SPI_mosi);
      end else begin
        cal_rise_cyc.push_back(cyc);
      end
    end
    if (!SPI_cs_n && prev_cs) cs_fall_cyc.push_back(cyc);
    if (SPI_cs_n && !prev_cs) cs_rise_cyc.push_back(cyc);
    if (cal_done) cal_done_cyc.push_back(cyc);
    prev_clk = SPI_clk;
    prev_cs  = SPI_cs_n;
  end

  int n_cmp = 0;
  int n_err = 0;
  int hs_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge CLK_40);
    byte_in    = d;
    byte_last  = l;
    byte_valid = 1'b1;
    while (!byte_ready && n < 10000) begin
      @(negedge CLK_40);
      n++;
    end
    if (!byte_ready) chk("push_timeout", 0, 1);
    @(posedge CLK_40);
    @(negedge CLK_40);
    hs_cyc     = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic wait_cs_rise(input int start, input int budget, input string name);
    int n;
    n = 0;
    while (cs_rise_cyc.size() <= start && n < budget) begin
      @(negedge CLK_40);
      n++;
    end
    if (cs_rise_cyc.size() <= start) chk(name, 0, 1);
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rise_cyc.size() < target && n < budget) begin
      @(negedge CLK_40);
      n++;
    end
    if (rise_cyc.size() < target) chk(name, 0, 1);
  endtask

  function automatic int byte_at(input int idx);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      v = (v << 1) | ((idx + i < rise_bit.size()) ? int'(rise_bit[idx + i]) : 0);
    end
    return v;
  endfunction

  typedef struct {
    logic [7:0] data;
    int         exp_bits;
    int         exp_first;
    int         exp_last;
    int         exp_cs_rise;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] fb[17];

  initial begin
    int sr, sf, scr, scal, scd, t, c0, msb_cyc, bad;

    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sr, sf, scr, scal, scd, t, c0, msb_cyc;
    vecs[0] = '{8'hA5, 8'b1010_0101, 20, 300, 340};
    vecs[1] = '{8'h00, 8'b0000_0000, 20, 300, 340};
    vecs[2] = '{8'hFF, 8'b1111_1111, 20, 300, 340};
    vecs[3] = '{8'h01, 8'b0000_0001, 20, 300, 340};
    vecs[4] = '{8'h80, 8'b1000_0000, 20, 300, 340};

    // Reset state
    repeat (3) @(negedge CLK_40);
    chk("rst_clk", SPI_clk, 0);
    chk("rst_mosi", SPI_mosi, 0);
    chk("rst_cs_n", SPI_cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cal_done", cal_done, 0);
    chk("rst_ready", byte_ready, 1);
    reset = 1'b0;
    repeat (3) @(negedge CLK_40);

    // Single-byte frames from the table
    for (int v = 0; v < 5; v++) begin
      sr = rise_cyc.size(); sf = cs_fall_cyc.size(); scr = cs_rise_cyc.size();
      push(vecs[v].data, 1'b1);
      wait_cs_rise(scr, 1000, "single_cs_timeout");
      t = (cs_fall_cyc.size() > sf) ? cs_fall_cyc[sf] : 0;
      chk("single_latency", t - hs_cyc, 1);
      chk("single_nrise", rise_cyc.size() - sr, 8);
      if (rise_cyc.size() >= sr + 8) begin
        chk("single_first_rise", rise_cyc[sr] - t, vecs[v].exp_first);
        chk("single_last_rise", rise_cyc[sr + 7] - t, vecs[v].exp_last);
      end
      chk("single_bits", byte_at(sr), vecs[v].exp_bits);
      if (cs_rise_cyc.size() > scr) chk("single_cs_rise", cs_rise_cyc[scr] - t, vecs[v].exp_cs_rise);
      repeat (2) @(negedge CLK_40);
      chk("single_idle_busy", busy, 0);
    end

    // Back-to-back bytes
    sr = rise_cyc.size(); sf = cs_fall_cyc.size(); scr = cs_rise_cyc.size();
    push(8'h3C, 1'b0);
    push(8'hF0, 1'b1);
    wait_cs_rise(scr, 2000, "b2b_cs_timeout");
    t = (cs_fall_cyc.size() > sf) ? cs_fall_cyc[sf] : 0;
    chk("b2b_nrise", rise_cyc.size() - sr, 16);
    if (rise_cyc.size() >= sr + 16) begin
      msb_cyc = 0;
      for (int i = 1; i < 16; i++) if (rise_cyc[sr + i] - rise_cyc[sr + i - 1] != 40) msb_cyc++;
      chk("b2b_spacing_errors", msb_cyc, 0);
    end
    chk("b2b_byte0", byte_at(sr), 8'h3C);
    chk("b2b_byte1", byte_at(sr + 8), 8'hF0);
    chk("b2b_mosi_before_msb", mosi_hist[t + 319], 0);
    chk("b2b_second_msb", mosi_hist[t + 320], 1);
    if (cs_rise_cyc.size() > scr) chk("b2b_cs_rise", cs_rise_cyc[scr] - t, 660);
    repeat (2) @(negedge CLK_40);

    // Underrun: first byte drains, line parks in HOLD
    sr = rise_cyc.size(); sf = cs_fall_cyc.size(); scr = cs_rise_cyc.size();
    push(8'h81, 1'b0);
    wait_rises(sr + 8, 1000, "under_rise_timeout");
    repeat (200) @(negedge CLK_40);
    chk("hold_clk", SPI_clk, 0);
    chk("hold_cs_n", SPI_cs_n, 0);
    chk("hold_busy", busy, 1);
    chk("hold_mosi", SPI_mosi, 1);
    push(8'h7E, 1'b1);
    wait_cs_rise(scr, 1000, "under_cs_timeout");
    chk("under_nrise", rise_cyc.size() - sr, 16);
    chk("under_cs_rise_count", cs_rise_cyc.size() - scr, 1);
    chk("under_byte0", byte_at(sr), 8'h81);
    chk("under_byte1", byte_at(sr + 8), 8'h7E);
    if (rise_cyc.size() >= sr + 16) begin
      msb_cyc = 0;
      for (int c = rise_cyc[sr + 7]; c < rise_cyc[sr + 8]; c++)
        if (msb_cyc == 0 && mosi_hist[c] == 1'b0) msb_cyc = c;
      chk("under_msb_latency", msb_cyc - hs_cyc, 1);
      chk("under_msb_to_rise", rise_cyc[sr + 8] - msb_cyc, 20);
      if (cs_rise_cyc.size() > scr) chk("under_cs_rise", cs_rise_cyc[scr] - rise_cyc[sr + 15], 40);
    end
    repeat (2) @(negedge CLK_40);

    // Calibration requested while the FIFO holds a byte
    sr = rise_cyc.size(); sf = cs_fall_cyc.size(); scr = cs_rise_cyc.size();
    scal = cal_rise_cyc.size(); scd = cal_done_cyc.size();
    @(negedge CLK_40);
    byte_in = 8'h5A; byte_last = 1'b1; byte_valid = 1'b1;
    @(negedge CLK_40);
    byte_valid = 1'b0; cal_start = 1'b1;
    @(negedge CLK_40);
    cal_start = 1'b0;
    c0 = cyc;
    chk("cal_busy", busy, 1);
    chk("cal_cs_n", SPI_cs_n, 1);
    wait_cs_rise(scr, 1500, "cal_cs_timeout");
    chk("cal_done_count", cal_done_cyc.size() - scd, 1);
    if (cal_done_cyc.size() > scd) chk("cal_done_cycle", cal_done_cyc[scd] - c0, 159);
    chk("cal_nrise", cal_rise_cyc.size() - scal, 4);
    if (cal_rise_cyc.size() >= scal + 4) begin
      chk("cal_first_rise", cal_rise_cyc[scal] - c0, 20);
      chk("cal_last_rise", cal_rise_cyc[scal + 3] - c0, 140);
    end
    chk("cal_clk_low_after", mosi_hist[c0 + 160], 0);
    if (cs_fall_cyc.size() > sf) chk("cal_then_select", cs_fall_cyc[sf] - c0, 161);
    chk("cal_frame_nrise", rise_cyc.size() - sr, 8);
    chk("cal_frame_bits", byte_at(sr), 8'h5A);
    repeat (2) @(negedge CLK_40);

    // Full FIFO: fill during a calibration burst so nothing drains
    for (int i = 0; i < 17; i++) fb[i] = 8'(i * 37 + 11);
    sr = rise_cyc.size(); sf = cs_fall_cyc.size(); scr = cs_rise_cyc.size();
    @(negedge CLK_40);
    cal_start = 1'b1;
    @(negedge CLK_40);
    cal_start = 1'b0;
    for (int i = 0; i < 16; i++) push(fb[i], 1'b0);
    chk("full_ready_low", byte_ready, 0);
    chk("full_still_cal", SPI_cs_n, 1);
    push(fb[16], 1'b1);
    chk("full_17th_after_pop", (cs_fall_cyc.size() > sf) ? 1 : 0, 1);
    wait_cs_rise(scr, 8000, "full_cs_timeout");
    chk("full_nrise", rise_cyc.size() - sr, 136);
    for (int i = 0; i < 17; i++) chk("full_order", byte_at(sr + 8 * i), int'(fb[i]));
    if (cs_fall_cyc.size() > sf && cs_rise_cyc.size() > scr)
      chk("full_cs_rise", cs_rise_cyc[scr] - cs_fall_cyc[sf], 5460);
    repeat (2) @(negedge CLK_40);

    // Reset during bit 3 with a second byte queued
    sr = rise_cyc.size();
    push(8'hC3, 1'b0);
    push(8'h11, 1'b1);
    wait_rises(sr + 4, 1000, "rst_mid_timeout");
    @(negedge CLK_40);
    reset = 1'b1;
    @(negedge CLK_40);
    chk("rst_mid_cs_n", SPI_cs_n, 1);
    chk("rst_mid_clk", SPI_clk, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mosi", SPI_mosi, 0);
    chk("rst_mid_ready", byte_ready, 1);
    reset = 1'b0;
    sr = rise_cyc.size();
    repeat (50) @(negedge CLK_40);
    chk("rst_flush_cs_n", SPI_cs_n, 1);
    chk("rst_flush_busy", busy, 0);
    chk("rst_flush_nrise", rise_cyc.size() - sr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
# spi_frame_tx

SPI transmitter for the CLK_40 domain and the sending end of the SPI link. It is used for loopback and board-to-board streaming of frame data, and it drives the receive path's edge-detect and phase-calibration logic. Bytes arrive through a valid/ready handshake and are buffered in a small FIFO. Each byte goes out MSB-first on SPI_mosi with a generated SPI_clk, and a calibration burst (free-running SPI_clk, chip-select high) can be issued on request.

## Interface
- CLK_DIV, 20: SPI_clk half-period in CLK_40 cycles (≥2); one bit lasts 2*CLK_DIV cycles.
- FIFO_DEPTH, 16: byte FIFO entries (power of 2).
- CAL_CYCLES, 64: full SPI_clk periods per calibration burst (≥1).
- CLK_40  in  1  system clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- byte_in  in  8  data byte.
- byte_last  in  1  qualifies byte_in as the final byte of a frame.
- byte_valid  in  1  byte_in/byte_last valid.
- byte_ready  out  1  FIFO not full; a transfer happens when byte_valid && byte_ready.
- cal_start  in  1  request a calibration burst.
- SPI_clk  out  1  serial clock, idle low, registered.
- SPI_mosi  out  1  serial data, changes only on SPI_clk falling edges or at CS assertion, registered.
- SPI_cs_n  out  1  chip select, active low, registered.
- busy  out  1  FSM is not in IDLE.
- cal_done  out  1  one-cycle pulse when a calibration burst ends.

## Operation
- **Reset values:** SPI_clk=0, SPI_mosi=0, SPI_cs_n=1, busy=0, cal_done=0. FIFO is emptied, so byte_ready=1. Reset asserted mid-transfer aborts it and returns to these values on the next edge.
- **FSM states:** IDLE, CAL, SELECT, SHIFT, HOLD, GAP.
- **IDLE:**
  - cal_start → CAL. cal_start has priority over a non-empty FIFO.
  - Otherwise, FIFO non-empty → SELECT. The head entry is popped into the shift register.
  - cal_start is ignored outside IDLE.
- **CAL:** SPI_cs_n=1, SPI_mosi=0, and SPI_clk toggles every CLK_DIV cycles for CAL_CYCLES full periods, ending low. cal_done pulses and the FSM returns to IDLE.
- **SELECT:** SPI_cs_n=0 and SPI_mosi=bit7 in the entry cycle. After CLK_DIV cycles → SHIFT.
- **SHIFT:**
  - A phase counter counts 0..CLK_DIV-1. SPI_clk toggles on wrap.
  - A rising toggle is the sample point. A falling toggle advances the bit index 7→0 and drives the next bit.
  - After the falling edge of bit 0:
    - If the byte is last → GAP.
    - Else, if the FIFO is non-empty: pop the next byte and drive its bit7 on that same falling edge (seamless).
    - Else → HOLD.
- **HOLD:** SPI_clk=0, SPI_cs_n=0, SPI_mosi holds its value. When the FIFO becomes non-empty: pop the byte, drive its bit7, and the next rising edge follows CLK_DIV cycles later.
- **GAP:** SPI_cs_n stays 0 for CLK_DIV cycles, then goes to 1 with SPI_mosi=0 → IDLE. The FSM stays in IDLE for at least one cycle before a new SELECT.
- **Simultaneous push and pop:** allowed. The count is unchanged and a push into a full FIFO is impossible.
- **Counters:**
  - Phase counter width is $clog2(CLK_DIV).
  - Bit index is 3 bits.
  - The calibration counter counts half-periods up to 2*CAL_CYCLES; width is $clog2(2*CAL_CYCLES+1).
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with full/empty decided by the MSB.

## Timing
- The FIFO push is visible to the FSM one cycle after the handshake. IDLE→SELECT takes one more cycle.
- Let T be the cycle SPI_cs_n falls:
  - Bit k (k=0 for MSB) rises at T+(2k+1)*CLK_DIV and falls at T+(2k+2)*CLK_DIV.
  - The last falling edge is at T+16*CLK_DIV.
  - For a last byte, SPI_cs_n rises at T+17*CLK_DIV.
- Back-to-back bytes produce no clock gap. The byte period is 16*CLK_DIV cycles.
- CAL lasts 2*CAL_CYCLES*CLK_DIV cycles. cal_done is asserted in the last one.
- All SPI outputs come from flops, with no combinational paths from inputs. byte_ready = !full is combinational from FIFO state only.

## Structure
- Shared package holds the state typedef (tx_state_t, 3-bit enum) and the SPI idle constants (CLK idle low, CS idle high).
- One sub-module, tx_byte_fifo: synchronous single-clock FIFO, 9 bits wide (byte_last + byte_in), with push/pop/full/empty and synchronous reset flush.
- The top level contains the FSM, phase counter, bit index, shift register and calibration counter.

## Test plan
- **Single byte:** CLK_DIV=20, push 0xA5 with byte_last=1 → rising edges at T+20, 60, …, 300; MOSI sampled 1,0,1,0,0,1,0,1; SPI_cs_n rises at T+340.
- **Back-to-back bytes:** push 0x3C then 0xF0(last) with no stall → 16 rising edges spaced 40 cycles apart; second MSB appears at T+320; SPI_cs_n rises at T+660.
- **Underrun:** push 0x81 (not last), then wait 200 cycles before pushing 0x7E(last) → SPI_clk low and SPI_cs_n low during HOLD; the first rising edge of 0x7E comes 20 cycles after its MSB is driven.
- **Calibration:** CAL_CYCLES=4, pulse cal_start while the FIFO also holds data → 4 SPI_clk periods with SPI_cs_n=1; cal_done at cycle 160 of CAL; the data frame follows.
- **Full FIFO:** push 17 bytes without draining → byte_ready=0 after 16; the 17th is held until a pop; all 17 bytes are transmitted in order.
- **Reset mid-transfer:** assert reset during bit 3 → next edge has SPI_cs_n=1, SPI_clk=0, busy=0, FIFO empty.
